// File: rtl/aes_128_in_framer_if.sv
// ---------------------------------------------------------------------------
// aes_128_in_framer_if
// Word-stream handshake between an upstream producer and the AES-128 input
// framer. A word moves on any rising edge where s_valid && s_ready.
//   s_valid : producer has a word on s_data
//   s_ready : framer can take a word this cycle
//   s_data  : stream word (frame order: PT MS word first, then KEY MS first)
// Modports: master = producer side, slave = framer side.
// ---------------------------------------------------------------------------
interface aes_128_in_framer_if #(
   parameter int WORD_W = 32
);
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/aes_128_in_framer.sv
// ---------------------------------------------------------------------------
// aes_128_in_framer
// Collects 8 stream words (4 plaintext, then 4 key, MS word first) into a
// shadow frame and launches it to a multicycle AES-128 core with a one-cycle
// start pulse. Output registers in_bus/key only change on launch, so the
// next frame can be filled while the core is still working on the last one.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   s             : word stream (slave side of aes_128_in_framer_if)
//   in_bus, key   : registered block presented to the core
//   start         : one-cycle pulse, in_bus/key hold a new block
//   core_done     : core valid_ready pulse (result valid, core idle)
//   busy          : core owns a launched block not yet completed
//   blk_count     : launched-block counter, wraps
//   err_spurious  : sticky, core_done seen while not busy
// ---------------------------------------------------------------------------
module aes_128_in_framer #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   aes_128_in_framer_if.slave s,
   output logic [127:0]       in_bus,
   output logic [127:0]       key,
   output logic               start,
   input  logic               core_done,
   output logic               busy,
   output logic [CNT_W-1:0]   blk_count,
   output logic               err_spurious
);

   localparam int FRAME_WORDS = 256 / WORD_W;

   // FILL accepts words. FULL covers both waiting for the core (HOLD) and
   // the single launch cycle, which is decided combinationally from busy and
   // core_done and always returns to FILL on the following edge.
   typedef enum logic {ST_FILL, ST_FULL} state_t;

   state_t             state_reg, state_next;
   logic [2:0]         wcnt_reg;
   logic [255:0]       frame_shadow;
   logic [127:0]       in_bus_reg, key_reg;
   logic               start_reg, busy_reg, err_reg;
   logic [CNT_W-1:0]   blk_count_reg;
   logic               s_ready_c, accept, launch;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_FILL;
      else     state_reg <= state_next;
   end

   // ---------------- FSM: next state / outputs ----------------
   always_comb begin
      state_next = state_reg;
      s_ready_c  = 1'b0;
      accept     = 1'b0;
      launch     = 1'b0;
      case (state_reg)
         ST_FILL: begin
            s_ready_c = !rst;
            accept    = s_ready_c && s.s_valid;
            if (accept && wcnt_reg == 3'(FRAME_WORDS - 1))
               state_next = ST_FULL;
         end
         ST_FULL: begin
            // A core_done in this cycle frees the core for a back-to-back launch.
            launch = !busy_reg || core_done;
            if (launch)
               state_next = ST_FILL;
         end
         default: state_next = ST_FILL;
      endcase
   end

   assign s.s_ready = s_ready_c;

   // ---------------- word counter ----------------
   always_ff @(posedge clk) begin
      if (rst)         wcnt_reg <= 3'd0;
      else if (accept) wcnt_reg <= wcnt_reg + 3'd1;
   end

   // ---------------- shadow frame slots ----------------
   // Slot gi holds stream word gi; slot 0 lands in the MS word of the frame.
   genvar gi;
   generate
      for (gi = 0; gi < FRAME_WORDS; gi++) begin : g_slot
         logic [WORD_W-1:0] slot_reg;
         always_ff @(posedge clk) begin
            if (rst)
               slot_reg <= '0;
            else if (accept && wcnt_reg == 3'(gi))
               slot_reg <= s.s_data;
         end
         assign frame_shadow[255 - WORD_W*gi -: WORD_W] = slot_reg;
      end
   endgenerate

   // ---------------- launch registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         in_bus_reg    <= '0;
         key_reg       <= '0;
         start_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         blk_count_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         start_reg <= launch;
         if (launch) begin
            in_bus_reg    <= frame_shadow[255:128];
            key_reg       <= frame_shadow[127:0];
            blk_count_reg <= blk_count_reg + 1'b1;
         end
         // Launch wins over completion so a back-to-back block keeps busy high.
         if (launch)
            busy_reg <= 1'b1;
         else if (core_done && busy_reg)
            busy_reg <= 1'b0;
         if (core_done && !busy_reg)
            err_reg <= 1'b1;
      end
   end

   assign in_bus       = in_bus_reg;
   assign key          = key_reg;
   assign start        = start_reg;
   assign busy         = busy_reg;
   assign blk_count    = blk_count_reg;
   assign err_spurious = err_reg;

endmodule
